explode_sequencer: RTL and testbench
====================================

# explode_sequencer

Game-over animation controller for the asteroid-avoider display path. It watches for a ship/asteroid collision, then drives the 4-bit frame select of the explosion/end-screen pixel ROM through its full sequence at a frame-tick rate: burst frames 1–4, all-red flash 5, then a blinking END screen (6/0). It holds the END screen until the player restarts, and it gates gameplay through `game_active`. It sits between the game-logic collision detector and the explosion pixel ROM, paced by the shared frame-tick divider.

## Interface
- `FRAME_TICKS`, default 4: ticks each burst frame (positions 1–4) is displayed; legal range 1–255.
- `RED_TICKS`, default 8: ticks the all-red frame (position 5) is displayed; legal range 1–255.
- `BLINK_TICKS`, default 16: ticks per half-period of the END blink (6 ↔ 0); legal range 1–255.
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle frame-rate enable pulse from the divider; all animation timing counts these.
- `collision` in 1: level or pulse from the collision detector; sampled every clock.
- `restart` in 1: player restart request; sampled every clock.
- `position` out 4: frame select to the explosion/end pixel ROM (0 = blank).
- `game_active` out 1: 1 = gameplay running; 0 freezes asteroid/ship movement.
- `done` out 1: 1 while the END screen is being displayed.

## Operation
- States: PLAY, BURST, RED, ENDSCR. An internal 8-bit tick counter `cnt` tracks elapsed ticks.
- All outputs are registered. Reset (async, `reset_n`=0) gives: state PLAY, `position`=0, `cnt`=0, `game_active`=1, `done`=0.
- PLAY: `position`=0. If `collision`=1 at a clock edge, the next state is BURST with `position`=1, `cnt`=0 and `game_active`=0. `restart` is ignored.
- BURST: on each `tick`, if `cnt`==`FRAME_TICKS`-1 then `cnt`←0 and the frame advances; otherwise `cnt`++.
  - Advancing from `position` 1–3 increments `position`.
  - Advancing from `position` 4 moves to RED with `position`=5.
- RED: counts `RED_TICKS` ticks the same way, then moves to ENDSCR with `position`=6, `done`=1 and `cnt`=0.
- ENDSCR: every `BLINK_TICKS` ticks, `position` toggles between 6 and 0. If `restart`=1, the next state is PLAY with `position`=0, `cnt`=0, `game_active`=1 and `done`=0.
- `collision` is ignored in every state except PLAY. `restart` is ignored in every state except ENDSCR.
- Without a `tick`, `cnt` and `position` hold their values. Only `collision` and `restart` cause transitions without a tick.
- `position` never takes a value outside {0,1,2,3,4,5,6}.

## Timing
- Collision to first frame: 1 cycle. `position`=1 and `game_active`=0 are visible after the edge that samples `collision`.
- With `tick` high every cycle:
  - Each burst frame lasts exactly `FRAME_TICKS` cycles.
  - The red frame lasts exactly `RED_TICKS` cycles.
  - The first ENDSCR cycle follows after 4·`FRAME_TICKS`+`RED_TICKS` cycles.
- A frame change occurs on the same edge that samples the final `tick` of the count.
- Restart to gameplay: 1 cycle. `restart` takes priority over a same-cycle `tick` in ENDSCR, so no blink toggle occurs on that edge.
- In PLAY, a same-cycle `collision` and `restart` resolve in favour of `collision`.
- `reset_n` asserted mid-sequence forces the reset values immediately, with no clock needed. Release is synchronous to the next `clk` edge.
- A `collision` held high after restart re-triggers BURST on the first PLAY cycle. This is intended.

## Test plan
- **Reset:** assert `reset_n`=0 mid-BURST with `position`=3 → immediately `position`=0, `game_active`=1, `done`=0. After release with no collision, all outputs stay unchanged for 20 cycles.
- **Full sequence** (`FRAME_TICKS`=2, `RED_TICKS`=3, `BLINK_TICKS`=2, `tick` every cycle): pulse `collision` for 1 cycle → `position` per cycle is 1,1,2,2,3,3,4,4,5,5,5,6,6,0,0,6,6. `done` rises with the first 6. `game_active`=0 throughout.
- **Sparse ticks:** same parameters with `tick` every 3rd cycle → each burst frame lasts 6 cycles and red lasts 9 cycles. `position` is unchanged on non-tick cycles.
- **Ignored inputs:**
  - `restart` pulses during BURST/RED cause no state or `position` change.
  - `collision` pulses during RED/ENDSCR cause no change.
- **Restart priority:** in ENDSCR with `position`=6, `restart` and `tick` asserted together → next cycle `position`=0, `game_active`=1, `done`=0, state PLAY. A `collision` on the following cycle restarts the burst at `position`=1.
- **Simultaneous inputs in PLAY:** `collision`=1 and `restart`=1 in the same cycle → BURST entered with `position`=1.

Source files
------------

// File: rtl/explode_sequencer.sv
// explode_sequencer: game-over animation controller.
// Watches for a collision, steps the explosion ROM frame select through
// burst frames 1-4, the all-red frame 5 and a blinking END screen (6/0),
// then waits for the player to restart. Gameplay is frozen via game_active.
module explode_sequencer #(
    parameter int unsigned FRAME_TICKS = 4,
    parameter int unsigned RED_TICKS   = 8,
    parameter int unsigned BLINK_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       collision,
    input  logic       restart,
    output logic [3:0] position,
    output logic       game_active,
    output logic       done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned POS_W = 4;

    localparam logic [POS_W-1:0] POS_BLANK      = POS_W'(0);
    localparam logic [POS_W-1:0] POS_FIRST      = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST_BURST = POS_W'(4);
    localparam logic [POS_W-1:0] POS_RED        = POS_W'(5);
    localparam logic [POS_W-1:0] POS_END        = POS_W'(6);

    // Terminal count values: a frame ends on the tick that sees cnt == N-1.
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_BURST  = 2'd1,
        S_RED    = 2'd2,
        S_ENDSCR = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic               game_active_q, game_active_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   cnt_last_c;
    logic               step_done_c;

    // Terminal count for the current phase and the "this tick ends the frame" flag.
    always_comb begin
        cnt_last_c = '0;
        case (state_q)
            S_BURST:  cnt_last_c = FRAME_LAST;
            S_RED:    cnt_last_c = RED_LAST;
            S_ENDSCR: cnt_last_c = BLINK_LAST;
            default:  cnt_last_c = '0;
        endcase
        step_done_c = tick && (cnt_q == cnt_last_c);
    end

    // State and output registers; async reset returns to gameplay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_PLAY;
            cnt_q         <= '0;
            position_q    <= POS_BLANK;
            game_active_q <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            position_q    <= position_d;
            game_active_q <= game_active_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic: collision only matters in PLAY, restart only in ENDSCR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLAY: begin
                if (collision) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (step_done_c && (position_q == POS_LAST_BURST)) begin
                    state_d = S_RED;
                end
            end
            S_RED: begin
                if (step_done_c) begin
                    state_d = S_ENDSCR;
                end
            end
            S_ENDSCR: begin
                if (restart) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_PLAY;
        endcase
    end

    // Output/counter logic: counters and frame select move only on ticks.
    always_comb begin
        cnt_d         = cnt_q;
        position_d    = position_q;
        game_active_d = game_active_q;
        done_d        = done_q;
        case (state_q)
            S_PLAY: begin
                position_d = POS_BLANK;
                if (collision) begin
                    position_d    = POS_FIRST;
                    cnt_d         = '0;
                    game_active_d = 1'b0;
                    done_d        = 1'b0;
                end
            end
            S_BURST: begin
                if (tick) begin
                    if (step_done_c) begin
                        cnt_d = '0;
                        if (position_q == POS_LAST_BURST) begin
                            position_d = POS_RED;
                        end else begin
                            position_d = position_q + POS_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RED: begin
                if (tick) begin
                    if (step_done_c) begin
                        cnt_d      = '0;
                        position_d = POS_END;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ENDSCR: begin
                // Restart wins over a same-cycle tick, so no blink toggle here.
                if (restart) begin
                    position_d    = POS_BLANK;
                    cnt_d         = '0;
                    game_active_d = 1'b1;
                    done_d        = 1'b0;
                end else if (tick) begin
                    if (step_done_c) begin
                        cnt_d      = '0;
                        position_d = (position_q == POS_END) ? POS_BLANK : POS_END;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                position_d    = POS_BLANK;
                cnt_d         = '0;
                game_active_d = 1'b1;
                done_d        = 1'b0;
            end
        endcase
    end

    assign position    = position_q;
    assign game_active = game_active_q;
    assign done        = done_q;

    // Structural invariants of the registered outputs.
    a_pos_range: assert property (@(posedge clk) disable iff (!reset_n)
        position_q <= POS_END);
    a_done_endscr: assert property (@(posedge clk) disable iff (!reset_n)
        done_q == (state_q == S_ENDSCR));
    a_active_play: assert property (@(posedge clk) disable iff (!reset_n)
        game_active_q == (state_q == S_PLAY));
    a_play_blank: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == S_PLAY) |-> (position_q == POS_BLANK));

endmodule

// File: tb/tb_explode_sequencer.sv
// Bench for explode_sequencer: tick-count reference model plus directed
// literal expectations for the full sequence, sparse ticks, restart and reset.
module tb_explode_sequencer;

    localparam int unsigned F     = 2;
    localparam int unsigned R     = 3;
    localparam int unsigned B     = 2;
    localparam int          END_T = 4 * F + R;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       collision;
    logic       restart;
    logic [3:0] position;
    logic       game_active;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: either playing, or a count of ticks seen since the collision.
    bit m_play;
    int m_t;

    always #5 clk = ~clk;

    explode_sequencer #(
        .FRAME_TICKS(F),
        .RED_TICKS  (R),
        .BLINK_TICKS(B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .collision  (collision),
        .restart    (restart),
        .position   (position),
        .game_active(game_active),
        .done       (done)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pos(input bit play, input int t);
        if (play)           return 0;
        if (t < 4 * F)      return t / F + 1;
        if (t < END_T)      return 5;
        return (((t - END_T) / B) % 2 == 0) ? 6 : 0;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_play <= 1'b1;
            m_t    <= 0;
        end else if (m_play) begin
            if (collision) begin
                m_play <= 1'b0;
                m_t    <= 0;
            end
        end else if (m_t >= END_T && restart) begin
            m_play <= 1'b1;
        end else if (tick) begin
            m_t <= m_t + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_position", 8'(position), 8'(model_pos(m_play, m_t)));
            chk("model_game_active", 8'(game_active), 8'(m_play));
            chk("model_done", 8'(done), 8'(!m_play && m_t >= END_T));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for a given position value, sampled on the falling edge.
    task automatic wait_pos(input logic [3:0] p, input int max_cyc, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if (position == p) found = 1'b1;
        end
        chk(nm, 8'(found), 8'd1);
    endtask

    // Drive the design back to gameplay through the END screen.
    task automatic go_play();
        bit found = 1'b0;
        collision = 1'b0;
        restart   = 1'b0;
        tick      = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1'b1;
        end
        chk("reach_endscr", 8'(found), 8'd1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        logic [3:0] full_seq [17];
        logic [3:0] sparse_q [$];
        int         hist [7];

        full_seq = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5,
                     4'd5, 4'd5, 4'd6, 4'd6, 4'd0, 4'd0, 4'd6, 4'd6};

        reset_n   = 1'b0;
        tick      = 1'b0;
        collision = 1'b0;
        restart   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("reset_position", 8'(position), 8'd0);
        chk("reset_game_active", 8'(game_active), 8'd1);
        chk("reset_done", 8'(done), 8'd0);

        // Full sequence with a tick every cycle and a one-cycle collision pulse.
        step();
        collision = 1'b1;
        tick      = 1'b1;
        step();
        collision = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk($sformatf("full_pos[%0d]", i), 8'(position), 8'(full_seq[i]));
            chk($sformatf("full_active[%0d]", i), 8'(game_active), 8'd0);
            chk($sformatf("full_done[%0d]", i), 8'(done), 8'(i >= 11));
        end

        // Restart together with a tick that would otherwise toggle 6 -> 0.
        restart = 1'b1;
        @(negedge clk);
        chk("restart_pos", 8'(position), 8'd0);
        chk("restart_active", 8'(game_active), 8'd1);
        chk("restart_done", 8'(done), 8'd0);
        restart   = 1'b0;
        collision = 1'b1;
        @(negedge clk);
        chk("recollide_pos", 8'(position), 8'd1);
        chk("recollide_active", 8'(game_active), 8'd0);
        collision = 1'b0;
        go_play();

        // Simultaneous collision and restart in PLAY enter the burst.
        collision = 1'b1;
        restart   = 1'b1;
        @(negedge clk);
        chk("simul_pos", 8'(position), 8'd1);
        collision = 1'b0;
        restart   = 1'b0;
        go_play();

        // Sparse ticks (every 3rd edge) with ignored restart/collision pulses.
        tick      = 1'b0;
        collision = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            sparse_q.push_back(position);
            tick      = (k % 3 == 0);
            restart   = (k % 4 == 1) && (k < 24);
            collision = (k >= 25) && (k % 2 == 0);
        end
        restart   = 1'b0;
        collision = 1'b0;
        foreach (hist[i]) hist[i] = 0;
        foreach (sparse_q[i]) if (sparse_q[i] <= 4'd6) hist[sparse_q[i]]++;
        chk("sparse_first", 8'(sparse_q[0]), 8'd1);
        chk("sparse_len1", 8'(hist[1]), 8'd6);
        chk("sparse_len2", 8'(hist[2]), 8'd6);
        chk("sparse_len3", 8'(hist[3]), 8'd6);
        chk("sparse_len4", 8'(hist[4]), 8'd6);
        chk("sparse_len5", 8'(hist[5]), 8'd9);
        chk("sparse_len6", 8'(hist[6]), 8'd3);
        go_play();

        // Randomized traffic, with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            tick      = 1'($urandom_range(0, 1));
            collision = ($urandom_range(0, 7) == 0);
            restart   = ($urandom_range(0, 5) == 0);
            reset_n   = ($urandom_range(0, 399) != 0);
        end
        step();
        reset_n   = 1'b1;
        tick      = 1'b1;
        collision = 1'b0;
        restart   = 1'b0;
        step();

        // Asynchronous reset mid-burst at position 3, without a clock edge.
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        collision = 1'b1;
        step();
        collision = 1'b0;
        wait_pos(4'd3, 50, "reach_pos3");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pos", 8'(position), 8'd0);
        chk("async_rst_active", 8'(game_active), 8'd1);
        chk("async_rst_done", 8'(done), 8'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_pos", 8'(position), 8'd0);
            chk("idle_active", 8'(game_active), 8'd1);
            chk("idle_done", 8'(done), 8'd0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
